// File: rtl/bridge_sequencer.sv
// bridge_sequencer: power-up, run, discharge and fault sequencing for an
// H-bridge with precharge relay, main contactor and gate dead-time control.
module bridge_sequencer #(
    parameter int unsigned FREQ      = 50000000,
    parameter int unsigned CHARGE_MS = 15000,
    parameter int unsigned SETTLE_MS = 1000,
    parameter int unsigned DEAD_CYC  = 50,
    parameter int unsigned NERR      = 6,
    parameter int unsigned FILT_CYC  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_strobe,
    input  logic [2:0]      cmd,
    input  logic [NERR-1:0] err_n,
    input  logic            stop_n,
    output logic [3:0]      top,
    output logic [3:0]      bot,
    output logic            plus,
    output logic            minus,
    output logic            pause_p,
    output logic            pause_n,
    output logic            fan,
    output logic            ch,
    output logic            st,
    output logic            fault,
    output logic [NERR:0]   fault_src,
    output logic            ready
);

    localparam int unsigned TICK = (FREQ / 1000 > 0) ? FREQ / 1000 : 1;
    localparam int unsigned FW   = $clog2(FILT_CYC + 1);
    localparam int unsigned DW   = $clog2(DEAD_CYC + 1);

    typedef enum logic [2:0] {
        S_OFF, S_CHARGE, S_SETTLE, S_RUN, S_DISCH, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_PAUSE = 3'd0, C_PLUS = 3'd1, C_MINUS = 3'd2, C_BALP = 3'd3,
        C_BALN  = 3'd4, C_START = 3'd5, C_STOP = 3'd6, C_ARM = 3'd7
    } cmd_t;

    // synchroniser stages
    logic [1:0]      strb_sync;
    logic            strb_d;
    logic [2:0]      cmd_m, cmd_s;
    logic [NERR-1:0] err_m, err_s;
    logic            stop_m, stop_s;

    // fault filter
    logic [FW-1:0]   filt_cnt [NERR];
    logic [NERR-1:0] err_hit;
    logic [NERR:0]   cause;
    logic            any_cause, all_clear;

    // sequencer state
    state_t          state, state_nx;
    logic [2:0]      seq, seq_nx;
    logic [2:0]      cur, cur_nx, tgt, tgt_nx;
    logic            dead, dead_nx;
    logic [DW-1:0]   dcnt, dcnt_nx;
    logic [31:0]     pre, pre_nx, ms, ms_nx;
    logic [NERR:0]   src_nx;
    logic            accept, tick, gates_on;
    cmd_t            code;

    // 2-FF synchronisers; active-low inputs reset to their idle (high) level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strb_sync <= '0;
            strb_d    <= 1'b0;
            cmd_m     <= '0;
            cmd_s     <= '0;
            err_m     <= '1;
            err_s     <= '1;
            stop_m    <= 1'b1;
            stop_s    <= 1'b1;
        end else begin
            strb_sync <= {strb_sync[0], cmd_strobe};
            strb_d    <= strb_sync[1];
            cmd_m     <= cmd;
            cmd_s     <= cmd_m;
            err_m     <= err_n;
            err_s     <= err_m;
            stop_m    <= stop_n;
            stop_s    <= stop_m;
        end
    end

    assign accept = strb_sync[1] & ~strb_d;
    assign code   = cmd_t'(cmd_s);
    assign tick   = (pre == 32'(TICK - 1));

    // per-input count of consecutive low cycles, saturating one short of the filter length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NERR; i++) filt_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NERR; i++) begin
                if (err_s[i])
                    filt_cnt[i] <= '0;
                else if (filt_cnt[i] < FW'(FILT_CYC - 1))
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
            end
        end
    end

    // fault causes: filtered err_n, unfiltered stop_n
    always_comb begin
        err_hit = '0;
        for (int unsigned i = 0; i < NERR; i++)
            err_hit[i] = ~err_s[i] && (filt_cnt[i] >= FW'(FILT_CYC - 1));
        cause     = {~stop_s, err_hit};
        any_cause = |cause;
        all_clear = (&err_s) & stop_s;
    end

    // sequencer register bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_OFF;
            seq       <= '0;
            cur       <= '0;
            tgt       <= '0;
            dead      <= 1'b0;
            dcnt      <= '0;
            pre       <= '0;
            ms        <= '0;
            fault_src <= '0;
        end else begin
            state     <= state_nx;
            seq       <= seq_nx;
            cur       <= cur_nx;
            tgt       <= tgt_nx;
            dead      <= dead_nx;
            dcnt      <= dcnt_nx;
            pre       <= pre_nx;
            ms        <= ms_nx;
            fault_src <= src_nx;
        end
    end

    // next-state: commands, timers, dead-time, discharge arming and fault entry
    always_comb begin
        state_nx = state;
        seq_nx   = seq;
        cur_nx   = cur;
        tgt_nx   = tgt;
        dead_nx  = dead;
        dcnt_nx  = dcnt;
        pre_nx   = pre;
        ms_nx    = ms;
        src_nx   = fault_src;

        if (dead) begin
            if (dcnt == '0) begin
                dead_nx = 1'b0;
                cur_nx  = tgt;
            end else begin
                dcnt_nx = dcnt - 1'b1;
            end
        end

        if (state == S_CHARGE || state == S_SETTLE) begin
            pre_nx = tick ? '0 : pre + 32'd1;
            if (tick && ms != '1) ms_nx = ms + 32'd1;
        end

        case (state)
            S_OFF: begin
                if (accept) begin
                    seq_nx = '0;
                    case (code)
                        C_START: state_nx = S_CHARGE;
                        C_ARM:   if (seq == 3'd0 || seq == 3'd2) seq_nx = seq + 3'd1;
                        C_PAUSE: if (seq == 3'd1 || seq == 3'd3) seq_nx = seq + 3'd1;
                        C_PLUS, C_BALP: begin
                            if (seq == 3'd4) begin
                                state_nx = S_DISCH;
                                dead_nx  = 1'b1;
                                dcnt_nx  = DW'(DEAD_CYC - 1);
                                tgt_nx   = cmd_s;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CHARGE: if (tick && ms == 32'(CHARGE_MS - 1)) state_nx = S_SETTLE;
            S_SETTLE: if (tick && ms == 32'(SETTLE_MS - 1)) state_nx = S_RUN;
            S_RUN: begin
                if (accept && cmd_s <= 3'd4 && (dead || cmd_s != cur)) begin
                    dead_nx = 1'b1;
                    dcnt_nx = DW'(DEAD_CYC - 1);
                    tgt_nx  = cmd_s;
                end
            end
            S_FAULT: begin
                src_nx = fault_src | cause;
                if (accept && code == C_STOP && all_clear) state_nx = S_OFF;
            end
            default: ;
        endcase

        // fault outranks a simultaneous shutdown
        if (state != S_OFF && state != S_FAULT) begin
            if (accept && code == C_STOP) state_nx = S_OFF;
            if (any_cause) begin
                state_nx = S_FAULT;
                src_nx   = fault_src | cause;
            end
        end

        if (state_nx != state) begin
            pre_nx = '0;
            ms_nx  = '0;
            if (state_nx != S_DISCH) begin
                cur_nx  = '0;
                tgt_nx  = '0;
                dead_nx = 1'b0;
                dcnt_nx = '0;
            end
            if (state_nx == S_OFF) src_nx = '0;
        end

        if (state_nx != S_OFF) seq_nx = '0;
    end

    assign gates_on = (state == S_RUN || state == S_DISCH) && !dead;

    // output decode from state and the active gate pattern
    always_comb begin
        top     = '0;
        bot     = '0;
        plus    = 1'b0;
        minus   = 1'b0;
        pause_p = 1'b0;
        pause_n = 1'b0;
        fan     = (state == S_CHARGE || state == S_SETTLE || state == S_RUN || state == S_FAULT);
        ch      = (state == S_CHARGE || state == S_SETTLE);
        st      = (state == S_SETTLE || state == S_RUN);
        fault   = (state == S_FAULT);
        ready   = (state == S_RUN);
        if (gates_on) begin
            case (cur)
                3'd1: begin top = 4'b0001; bot = 4'b0010; plus    = 1'b1; end
                3'd2: begin top = 4'b0010; bot = 4'b0001; minus   = 1'b1; end
                3'd3: begin top = 4'b0100; bot = 4'b1000; pause_p = 1'b1; end
                3'd4: begin top = 4'b1000; bot = 4'b0100; pause_n = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_sequencer.sv
// tb_bridge_sequencer: randomized self-checking bench with a table-driven
// reference model of gate patterns, dead-time gaps and the sequencing rules.
module tb_bridge_sequencer;

    localparam int unsigned FREQ      = 50000;
    localparam int unsigned CHARGE_MS = 15;
    localparam int unsigned SETTLE_MS = 1;
    localparam int unsigned DEAD_CYC  = 5;
    localparam int unsigned NERR      = 6;
    localparam int unsigned FILT_CYC  = 4;
    localparam int unsigned TICK      = FREQ / 1000;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_strobe;
    logic [2:0]      cmd;
    logic [NERR-1:0] err_n;
    logic            stop_n;
    logic [3:0]      top, bot;
    logic            plus, minus, pause_p, pause_n, fan, ch, st, fault, ready;
    logic [NERR:0]   fault_src;

    logic [11:0] gv;
    logic [4:0]  misc;
    assign gv   = {top, bot, plus, minus, pause_p, pause_n};
    assign misc = {fan, ch, st, fault, ready};

    int total = 0;
    int bad   = 0;
    int st_viol = 0;
    int k = 0;

    bridge_sequencer #(
        .FREQ(FREQ), .CHARGE_MS(CHARGE_MS), .SETTLE_MS(SETTLE_MS),
        .DEAD_CYC(DEAD_CYC), .NERR(NERR), .FILT_CYC(FILT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_strobe(cmd_strobe), .cmd(cmd),
        .err_n(err_n), .stop_n(stop_n), .top(top), .bot(bot),
        .plus(plus), .minus(minus), .pause_p(pause_p), .pause_n(pause_n),
        .fan(fan), .ch(ch), .st(st), .fault(fault),
        .fault_src(fault_src), .ready(ready)
    );

    always #5 clk = ~clk;

    // shoot-through monitor
    always @(negedge clk) if ((top & bot) != 4'b0000) st_viol <= st_viol + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference gate table: {top, bot, plus, minus, pause_p, pause_n}
    function automatic logic [11:0] pat_of(input int c);
        case (c)
            1: return {4'b0001, 4'b0010, 4'b1000};
            2: return {4'b0010, 4'b0001, 4'b0100};
            3: return {4'b0100, 4'b1000, 4'b0010};
            4: return {4'b1000, 4'b0100, 4'b0001};
            default: return 12'h000;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int c);
        cmd = 3'(c);
        cyc(2);
        cmd_strobe = 1'b1;
        cyc(4);
        cmd_strobe = 1'b0;
        cyc(4);
    endtask

    // send a command and count the all-zero gate cycles in the following window
    task automatic send_watch(input int c, output int zeros);
        cmd = 3'(c);
        cyc(2);
        cmd_strobe = 1'b1;
        zeros = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 4) cmd_strobe = 1'b0;
            if (gv == 12'h000) zeros++;
        end
    endtask

    // one cycle of the power-up script: start, then a pause code that must be ignored
    task automatic step();
        @(negedge clk);
        k++;
        case (k)
            4:  cmd_strobe = 1'b0;
            8:  cmd = 3'd0;
            10: cmd_strobe = 1'b1;
            14: cmd_strobe = 1'b0;
            default: ;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int z, n, c, model, old, x;
        logic [11:0] e;
        rst = 1'b1; cmd_strobe = 1'b0; cmd = 3'd0; err_n = '1; stop_n = 1'b1;
        #2 rst = 1'b0;
        #20;
        chk("rst_gates", gv, 0);
        chk("rst_misc", misc, 0);
        chk("rst_src", fault_src, 0);
        @(negedge clk); rst = 1'b1;
        cyc(3);

        // power-up timing
        cmd = 3'd5; cyc(2); cmd_strobe = 1'b1; k = 0;
        for (int i = 0; i < 50 && ch !== 1'b1; i++) step();
        chk("charge_seen", ch, 1);
        chk("charge_out", {fan, ch, st}, 3'b110);
        n = 0;
        while (st !== 1'b1 && n < int'(CHARGE_MS * TICK) + 100) begin step(); n++; end
        chk("charge_len", n, CHARGE_MS * TICK);
        chk("settle_out", {fan, ch, st, ready}, 4'b1110);
        n = 0;
        while (ready !== 1'b1 && n < int'(SETTLE_MS * TICK) + 100) begin step(); n++; end
        chk("settle_len", n, SETTLE_MS * TICK);
        chk("run_out", {fan, ch, st, ready}, 4'b1011);
        chk("run_gates", gv, 0);

        // alternate plus/minus
        model = 0;
        for (int i = 0; i < 10; i++) begin
            c = (i % 2 == 0) ? 1 : 2;
            send_watch(c, z);
            if (model != 0) chk("alt_gap", z, DEAD_CYC);
            chk("alt_pat", gv, pat_of(c));
            model = c;
        end

        // random pattern commands
        for (int i = 0; i < 16; i++) begin
            c = $urandom_range(0, 4);
            old = model;
            send_watch(c, z);
            if (old != 0 && c != 0) chk("rnd_gap", z, (c != old) ? DEAD_CYC : 0);
            chk("rnd_pat", gv, pat_of(c));
            model = c;
        end

        // start and discharge-arm are ignored in RUN
        send(5);
        chk("run_c5", gv, pat_of(model));
        chk("run_c5_rdy", ready, 1);
        send(7);
        chk("run_c7", gv, pat_of(model));
        chk("run_c7_rdy", ready, 1);

        // fault filter
        err_n[2] = 1'b0; cyc(3); err_n[2] = 1'b1; cyc(10);
        chk("filt3", fault, 0);
        chk("filt3_rdy", ready, 1);
        err_n[2] = 1'b0; cyc(10);
        chk("filt4_misc", misc, 5'b10010);
        chk("filt4_src", fault_src, 7'b0000100);
        chk("filt4_gates", gv, 0);
        send(6);
        chk("f_c6_held", fault, 1);
        err_n[2] = 1'b1; cyc(5);
        send(6);
        chk("f_exit_misc", misc, 0);
        chk("f_exit_src", fault_src, 0);
        chk("f_exit_gates", gv, 0);

        // discharge arming
        send(7); send(0); send(7); send(0);
        send_watch(3, z);
        chk("dis_p", gv, pat_of(3));
        chk("dis_misc", {ch, st, fault, ready}, 4'b0000);

        // emergency stop during discharge
        stop_n = 1'b0; cyc(4);
        chk("stop_fault", fault, 1);
        chk("stop_src", fault_src, 7'b1000000);
        chk("stop_gates", gv, 0);
        stop_n = 1'b1; cyc(4);
        send(6);
        chk("stop_exit", misc, 0);

        // aborted sequence
        send(7); send(0); send(2);
        chk("abort_gates", gv, 0);
        send_watch(1, z);
        chk("abort_then1", gv, 0);
        chk("abort_misc", misc, 0);

        // random final code after a full arm prefix
        for (int i = 0; i < 6; i++) begin
            x = $urandom_range(0, 4);
            send(7); send(0); send(7); send(0);
            send_watch(x, z);
            e = (x == 1 || x == 3) ? pat_of(x) : 12'h000;
            chk("dis_rnd", gv, e);
            send(6);
            chk("dis_rnd_off", gv, 0);
        end

        // asynchronous reset during SETTLE
        send(5);
        n = 0;
        while (st !== 1'b1 && n < int'(CHARGE_MS * TICK) + 100) begin @(negedge clk); n++; end
        chk("settle_reach", {ch, st}, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("arst_gates", gv, 0);
        chk("arst_misc", misc, 0);
        chk("arst_src", fault_src, 0);
        @(negedge clk); rst = 1'b1;
        cyc(3);
        send_watch(1, z);
        chk("post_rst_c1", gv, 0);
        chk("post_rst_misc", misc, 0);

        chk("no_shoot", st_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
